alu_logic_sequencer: RTL

- Control-step sequencer that sits directly upstream of the logical ALU.
- On each accepted logical instruction it drives the datapath strobes: Y load, operand onto bus, one-hot ALU select (in_and/in_or/in_neg/in_not), Z capture, Z-low writeback into Ra.
- Covers the T3..T5 execute steps of and, or, andi, ori, neg and not. Fetch and decode (T0..T2) stay in the main control unit, which hands off via start/done.

---
 rtl/miniSRC_pkg.sv | 104 ++++++++++
 rtl/alu_logic_sequencer_if.sv | 35 +++
 rtl/alu_logic_decode.sv | 48 ++++
 rtl/alu_logic_sequencer.sv | 76 +++++++
 4 files changed

// File: rtl/miniSRC_pkg.sv
// Shared miniSRC definitions: logical-op opcodes, sequencer states, decode and strobe bundles.
package miniSRC_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_WB,
    S_ERR
  } seq_state_t;

  // op_sel is one-hot {and, or, neg, not}
  typedef struct packed {
    logic       is_binary;
    logic       is_imm;
    logic       legal;
    logic [3:0] op_sel;
  } decode_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic gra;
    logic grb;
    logic grc;
    logic r_out;
    logic r_in;
    logic c_out;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic in_and;
    logic in_or;
    logic in_neg;
    logic in_not;
  } strobes_t;

  function automatic seq_state_t next_state(seq_state_t s, logic start, decode_t d);
    seq_state_t n;
    n = S_IDLE;
    case (s)
      S_IDLE: begin
        if (!start)            n = S_IDLE;
        else if (!d.legal)     n = S_ERR;
        else if (d.is_binary)  n = S_LOAD_Y;
        else                   n = S_EXEC;
      end
      S_LOAD_Y: n = S_EXEC;
      S_EXEC:   n = S_WB;
      default:  n = S_IDLE;
    endcase
    return n;
  endfunction

  // Moore strobes of a state; only EXEC looks at the decoded opcode.
  function automatic strobes_t strobes_for(seq_state_t s, decode_t d);
    strobes_t o;
    o = '0;
    case (s)
      S_LOAD_Y: begin
        o.busy  = 1'b1;
        o.grb   = 1'b1;
        o.r_out = 1'b1;
        o.y_in  = 1'b1;
      end
      S_EXEC: begin
        o.busy = 1'b1;
        o.z_in = 1'b1;
        {o.in_and, o.in_or, o.in_neg, o.in_not} = d.op_sel;
        if (d.is_imm) begin
          o.c_out = 1'b1;
        end else begin
          o.r_out = 1'b1;
          if (d.is_binary) o.grc = 1'b1;
          else             o.grb = 1'b1;
        end
      end
      S_WB: begin
        o.busy     = 1'b1;
        o.zlow_out = 1'b1;
        o.gra      = 1'b1;
        o.r_in     = 1'b1;
        o.done     = 1'b1;
      end
      S_ERR: begin
        o.busy = 1'b1;
        o.err  = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alu_logic_sequencer_if.sv
// Handshake and datapath-strobe bundle between the main control unit and the logic sequencer.
interface alu_logic_sequencer_if #(
  parameter int OPCODE_W = 5
);
  logic                start;
  logic [OPCODE_W-1:0] opcode;
  logic                busy;
  logic                done;
  logic                err;
  logic                gra;
  logic                grb;
  logic                grc;
  logic                r_out;
  logic                r_in;
  logic                c_out;
  logic                y_in;
  logic                z_in;
  logic                zlow_out;
  logic                in_and;
  logic                in_or;
  logic                in_neg;
  logic                in_not;

  modport master (
    output start, opcode,
    input  busy, done, err, gra, grb, grc, r_out, r_in, c_out,
           y_in, z_in, zlow_out, in_and, in_or, in_neg, in_not
  );

  modport slave (
    input  start, opcode,
    output busy, done, err, gra, grb, grc, r_out, r_in, c_out,
           y_in, z_in, zlow_out, in_and, in_or, in_neg, in_not
  );
endinterface

// File: rtl/alu_logic_decode.sv
// Combinational classification of logical-ALU opcodes; shared with the main control unit.
module alu_logic_decode
  import miniSRC_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output decode_t             dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_AND: begin
        dec.legal     = 1'b1;
        dec.is_binary = 1'b1;
        dec.op_sel    = 4'b1000;
      end
      OP_OR: begin
        dec.legal     = 1'b1;
        dec.is_binary = 1'b1;
        dec.op_sel    = 4'b0100;
      end
      OP_ANDI: begin
        dec.legal     = 1'b1;
        dec.is_binary = 1'b1;
        dec.is_imm    = 1'b1;
        dec.op_sel    = 4'b1000;
      end
      OP_ORI: begin
        dec.legal     = 1'b1;
        dec.is_binary = 1'b1;
        dec.is_imm    = 1'b1;
        dec.op_sel    = 4'b0100;
      end
      OP_NEG: begin
        dec.legal  = 1'b1;
        dec.op_sel = 4'b0010;
      end
      OP_NOT: begin
        dec.legal  = 1'b1;
        dec.op_sel = 4'b0001;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/alu_logic_sequencer.sv
// T3..T5 execute-step sequencer for and/or/andi/ori/neg/not, driving the logical-ALU datapath strobes.
module alu_logic_sequencer
  import miniSRC_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic                  clk,
  input  logic                  clr,
  alu_logic_sequencer_if.slave  bus
);

  seq_state_t          state;
  seq_state_t          nxt;
  logic [OPCODE_W-1:0] op_q;
  logic [OPCODE_W-1:0] dec_op;
  decode_t             dec;
  strobes_t            strb_q;

  // In IDLE the incoming opcode is decoded so that a unary op can enter EXEC with
  // its strobes already registered; afterwards only the latched copy matters.
  assign dec_op = (state == S_IDLE) ? bus.opcode : op_q;

  alu_logic_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .opcode(dec_op),
    .dec   (dec)
  );

  assign nxt = next_state(state, bus.start, dec);

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_IDLE;
      op_q   <= '0;
      strb_q <= '0;
    end else begin
      state  <= nxt;
      strb_q <= strobes_for(nxt, dec);
      if (state == S_IDLE && bus.start) begin
        op_q <= bus.opcode;
      end
    end
  end

  assign bus.busy     = strb_q.busy;
  assign bus.done     = strb_q.done;
  assign bus.err      = strb_q.err;
  assign bus.gra      = strb_q.gra;
  assign bus.grb      = strb_q.grb;
  assign bus.grc      = strb_q.grc;
  assign bus.r_out    = strb_q.r_out;
  assign bus.r_in     = strb_q.r_in;
  assign bus.c_out    = strb_q.c_out;
  assign bus.y_in     = strb_q.y_in;
  assign bus.z_in     = strb_q.z_in;
  assign bus.zlow_out = strb_q.zlow_out;
  assign bus.in_and   = strb_q.in_and;
  assign bus.in_or    = strb_q.in_or;
  assign bus.in_neg   = strb_q.in_neg;
  assign bus.in_not   = strb_q.in_not;

  a_one_bus_driver: assert property (@(posedge clk) disable iff (clr)
    $onehot0({strb_q.r_out, strb_q.c_out, strb_q.zlow_out}));

  a_one_reg_select: assert property (@(posedge clk) disable iff (clr)
    $onehot0({strb_q.gra, strb_q.grb, strb_q.grc}));

  a_alu_sel_exec_only: assert property (@(posedge clk) disable iff (clr)
    $onehot0({strb_q.in_and, strb_q.in_or, strb_q.in_neg, strb_q.in_not}) &&
    ((state == S_EXEC) || ({strb_q.in_and, strb_q.in_or, strb_q.in_neg, strb_q.in_not} == 4'b0000)));

  a_busy_non_idle: assert property (@(posedge clk) disable iff (clr)
    strb_q.busy == (state != S_IDLE));

endmodule
